// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution over one raster frame, one pixel per clock.
// Two line buffers plus a 2-column shift window; 2-cycle product/sum pipeline.
module conv3x3_stream #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int OUT_W = 32,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [PIX_W-1:0]        in_data,
  input  logic [9*WGT_W-1:0]      weights,
  input  logic signed [OUT_W-1:0] bias,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    frame_done
);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int PRD_W = PIX_W + WGT_W + 1;

  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [PIX_W-1:0]        r_lb1 [IMG_W];
  logic [PIX_W-1:0]        r_lb2 [IMG_W];
  logic [PIX_W-1:0]        r_c0 [3];
  logic [PIX_W-1:0]        r_c1 [3];
  logic [PIX_W-1:0]        w_col [3];
  logic [PIX_W-1:0]        w_pix [9];
  logic signed [PRD_W-1:0] w_prd [9];
  logic signed [PRD_W-1:0] r_prd [9];
  logic signed [OUT_W-1:0] r_bias;
  logic signed [OUT_W-1:0] w_sum;
  logic [2:1]              r_vld_pipe;
  logic [2:1]              r_last_pipe;
  logic                    w_col_end, w_row_end, w_fire;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_fire    = in_valid && (r_row >= RW'(2)) && (r_col >= CW'(2));

  // Window column entering this beat: oldest row on top, incoming pixel at bottom.
  always_comb begin
    w_col[0] = r_lb2[r_col];
    w_col[1] = r_lb1[r_col];
    w_col[2] = in_data;
    for (int r = 0; r < 3; r++) begin
      w_pix[3*r]     = r_c0[r];
      w_pix[3*r + 1] = r_c1[r];
      w_pix[3*r + 2] = w_col[r];
    end
    for (int k = 0; k < 9; k++)
      w_prd[k] = PRD_W'($signed({1'b0, w_pix[k]})) * PRD_W'($signed(weights[k*WGT_W +: WGT_W]));
  end

  always_comb begin
    w_sum = r_bias;
    for (int k = 0; k < 9; k++)
      w_sum = w_sum + {{(OUT_W-PRD_W){r_prd[k][PRD_W-1]}}, r_prd[k]};
  end

  // Storage without reset: refilled before any output depends on it.
  always_ff @(posedge clk) begin
    if (in_valid && !clr) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_data;
      for (int r = 0; r < 3; r++) begin
        r_c0[r] <= r_c1[r];
        r_c1[r] <= w_col[r];
      end
    end
    for (int k = 0; k < 9; k++) r_prd[k] <= w_prd[k];
    r_bias <= bias;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_col       <= '0;
      r_row       <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      out_data    <= '0;
    end else begin
      if (in_valid) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      r_vld_pipe  <= {r_vld_pipe[1], w_fire};
      r_last_pipe <= {r_last_pipe[1], w_fire && w_col_end && w_row_end};
      if (r_vld_pipe[1]) out_data <= w_sum;
    end
  end

  assign out_valid  = r_vld_pipe[2];
  assign frame_done = r_last_pipe[2];
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream: drives whole frames and checks every cycle's
// outputs against hand-derived per-test values with cycle-exact timing.
module tb_conv3x3_stream;
  logic               clk = 1'b0;
  logic               clr;
  logic               in_valid;
  logic [7:0]         in_data;
  logic [71:0]        weights;
  logic signed [31:0] bias;
  logic               out_valid;
  logic signed [31:0] out_data;
  logic               frame_done;

  always #5 clk = ~clk;

  conv3x3_stream dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .weights(weights), .bias(bias),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  typedef struct {
    int          stamp;
    logic [31:0] val;
    bit          last;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          k = 0, tr = 0, tc = 0, mode = 1;
  int          npulse = 0, ndone = 0;
  logic [31:0] last_val = '0;

  function automatic logic [7:0] pix(input int m, input int r, input int c);
    case (m)
      1:       return 8'd1;
      2:       return 8'((r*28 + c) % 256);
      default: return 8'd255;
    endcase
  endfunction

  // Hand-derived results: all-ones -> 9, centre tap -> x[orow+1][ocol+1], all -1 on 255 with bias 5 -> -2290.
  function automatic logic [31:0] expv(input int m, input int orow, input int ocol);
    case (m)
      1:       return 32'd9;
      2:       return 32'(((orow+1)*28 + ocol + 1) % 256);
      default: return 32'hFFFF_F70E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expct);
    checks++;
    assert (obs === expct) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expct);
    end
  endtask

  task automatic set_mode(input int m);
    mode    = m;
    weights = '0;
    for (int t = 0; t < 9; t++) begin
      if (m == 1) weights[t*8 +: 8] = 8'h01;
      if (m == 3) weights[t*8 +: 8] = 8'hFF;
    end
    if (m == 2) weights[4*8 +: 8] = 8'h01;
    bias = (m == 3) ? 32'sd5 : 32'sd0;
  endtask

  task automatic check_out();
    bit   due;
    exp_t e;
    due = (q.size() > 0) && (q[0].stamp == k);
    if (out_valid === 1'b1) npulse++;
    if (frame_done === 1'b1) ndone++;
    chk("out_valid", {31'b0, out_valid}, {31'b0, due});
    if (due) begin
      e = q.pop_front();
      chk("out_data", out_data, e.val);
      chk("frame_done", {31'b0, frame_done}, {31'b0, e.last});
      last_val = e.val;
    end else begin
      chk("hold_data", out_data, last_val);
      chk("idle_done", {31'b0, frame_done}, 32'd0);
    end
  endtask

  task automatic step(input bit v);
    exp_t e;
    @(negedge clk);
    k++;
    check_out();
    clr      = 1'b0;
    in_valid = v;
    in_data  = v ? pix(mode, tr, tc) : 8'h5A;
    if (v) begin
      if (tr >= 2 && tc >= 2) begin
        e.stamp = k + 2;
        e.val   = expv(mode, tr - 2, tc - 2);
        e.last  = (tr == 27 && tc == 27);
        q.push_back(e);
      end
      if (tc == 27) begin
        tc = 0;
        tr = (tr == 27) ? 0 : tr + 1;
      end else begin
        tc++;
      end
    end
  endtask

  task automatic drive_frame(input int gapmax, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic drain();
    repeat (4) step(1'b0);
  endtask

  // Anything still in flight when clr lands must never appear.
  task automatic do_clr();
    @(negedge clk);
    k++;
    check_out();
    q.delete();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tr       = 0;
    tc       = 0;
    last_val = '0;
  endtask

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    set_mode(1);
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);

    // 1: all ones
    npulse = 0; ndone = 0;
    drive_frame(0, 784); drain();
    chk("t1_pulses", npulse, 676);
    chk("t1_done", ndone, 1);

    // 2: ramp through centre tap
    set_mode(2); npulse = 0; ndone = 0;
    drive_frame(0, 784); drain();
    chk("t2_pulses", npulse, 676);
    chk("t2_done", ndone, 1);

    // 3: negative weights, positive bias
    set_mode(3); npulse = 0; ndone = 0;
    drive_frame(0, 784); drain();
    chk("t3_pulses", npulse, 676);
    chk("t3_done", ndone, 1);

    // clr must zero a nonzero out_data
    do_clr();
    step(1'b0);
    chk("clr_valid", {31'b0, out_valid}, 32'd0);
    chk("clr_data", out_data, 32'd0);

    // 4: ramp with random input gaps
    set_mode(2); npulse = 0; ndone = 0;
    drive_frame(3, 784); drain();
    chk("t4_pulses", npulse, 676);
    chk("t4_done", ndone, 1);

    // 5: abort after 100 pixels, then a clean frame
    set_mode(1);
    drive_frame(0, 100);
    do_clr();
    npulse = 0; ndone = 0;
    drive_frame(0, 784); drain();
    chk("t5_pulses", npulse, 676);
    chk("t5_done", ndone, 1);

    // 6: back-to-back frames
    set_mode(2); npulse = 0; ndone = 0;
    drive_frame(0, 784);
    drive_frame(0, 784);
    drain();
    chk("t6_pulses", npulse, 1352);
    chk("t6_done", ndone, 2);

    chk("q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
